// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// processor tick constants and the opcode field values of the 9-bit ISA.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] TICK_FETCH = 4'b0001;
  localparam logic [3:0] TICK_WB    = 4'b1000;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  localparam int WORD_W = 9;

endpackage

// File: rtl/instr_sequencer_buffer.sv
// instr_buffer: DEPTH x 9 program store. Synchronous write, combinational
// read, no reset (contents survive a sequencer reset by design).
import instr_sequencer_pkg::*;

module instr_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Store one instruction word per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a short program from the switches, then plays it
// back on din one word per processor instruction (tick 0001 = fetch,
// tick 1000 = write-back). Optional build macro INSTR_SEQ_LOOP_EN makes the
// program repeat forever instead of stopping in HALT.
import instr_sequencer_pkg::*;

module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic [3:0]        tick,
  output logic [WORD_W-1:0] din,
  output logic [AW-1:0]     pc,
  output logic [AW:0]       count,
  output logic              full,
  output logic              running,
  output logic              halted
);

  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  state_t            state_r;
  logic [AW:0]       count_r;
  logic [AW-1:0]     pc_r;
  logic              fetched_r;

  logic              full_s;
  logic              last_s;
  logic              load_go_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [WORD_W-1:0] rd_data_s;

  assign full_s    = (count_r == CNT_DEPTH);
  assign last_s    = ({1'b0, pc_r} == (count_r - CNT_ONE));
  // A write in the same cycle as start makes an empty buffer non-empty.
  assign load_go_s = start && ((count_r != {(AW+1){1'b0}}) || wr_en);

  // Buffer write port: append in LOAD, restart at address 0 from HALT.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = count_r[AW-1:0];
    case (state_r)
      ST_LOAD: begin
        we_s    = wr_en && !full_s;
        waddr_s = count_r[AW-1:0];
      end
      ST_HALT: begin
        we_s    = wr_en;
        waddr_s = {AW{1'b0}};
      end
      default: begin
        we_s    = 1'b0;
        waddr_s = count_r[AW-1:0];
      end
    endcase
  end

  instr_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wr_data),
    .raddr (pc_r),
    .rdata (rd_data_s)
  );

  // Sequencer FSM: load, play back on the processor's ticks, halt at end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_LOAD;
      count_r   <= {(AW+1){1'b0}};
      pc_r      <= {AW{1'b0}};
      fetched_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (wr_en && !full_s) begin
            count_r <= count_r + CNT_ONE;
          end
          if (load_go_s) begin
            state_r   <= ST_RUN;
            pc_r      <= {AW{1'b0}};
            fetched_r <= 1'b0;
          end
        end
        ST_RUN: begin
`ifdef INSTR_SEQ_LOOP_EN
          if (start) begin
            pc_r      <= {AW{1'b0}};
            fetched_r <= 1'b0;
          end else
`endif
          if (tick == TICK_FETCH) begin
            fetched_r <= 1'b1;
          end else if ((tick == TICK_WB) && fetched_r) begin
            // Only a write-back that follows our own fetch retires a word,
            // so a start landing mid-instruction still issues word 0 whole.
            fetched_r <= 1'b0;
            if (last_s) begin
`ifdef INSTR_SEQ_LOOP_EN
              pc_r <= {AW{1'b0}};
`else
              state_r <= ST_HALT;
`endif
            end else begin
              pc_r <= pc_r + PC_ONE;
            end
          end
        end
        ST_HALT: begin
          if (wr_en) begin
            state_r   <= ST_LOAD;
            count_r   <= CNT_ONE;
            pc_r      <= {AW{1'b0}};
            fetched_r <= 1'b0;
          end else if (start) begin
            state_r   <= ST_RUN;
            pc_r      <= {AW{1'b0}};
            fetched_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_LOAD;
          count_r   <= {(AW+1){1'b0}};
          pc_r      <= {AW{1'b0}};
          fetched_r <= 1'b0;
        end
      endcase
    end
  end

  assign din     = (state_r == ST_LOAD) ? {WORD_W{1'b0}} : rd_data_s;
  assign pc      = pc_r;
  assign count   = count_r;
  assign full    = full_s;
  assign running = (state_r == ST_RUN);
  assign halted  = (state_r == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer. The program buffer is
// modelled as a queue of words; each run pushes the words the processor must
// see at its fetch ticks, and a monitor pops them whenever the DUT is running
// on a fetch tick.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [8:0]    word;
    logic [AW-1:0] addr;
  } fetch_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [8:0]    wr_data;
  logic          start;
  logic [3:0]    tick;
  logic [8:0]    din;
  logic [AW-1:0] pc;
  logic [AW:0]   count;
  logic          full;
  logic          running;
  logic          halted;

  int     n_checks = 0;
  int     n_pass   = 0;
  fetch_t exp_q[$];
  logic [8:0] prog_q[$];
  bit     mon_strict = 1'b1;
  bit     illegal_en = 1'b0;
  logic [2:0] ops [4] = '{OP_MOVI, OP_ADD, OP_ADDI, OP_SUB};

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .tick(tick), .din(din), .pc(pc), .count(count), .full(full),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Processor tick generator: one-hot rotation, optionally with illegal
  // non-one-hot cycles inserted between legal ticks.
  initial begin
    logic [3:0] ph;
    ph = 4'b0001;
    tick = ph;
    forever begin
      @(posedge clk);
      #1;
      if (illegal_en && $urandom_range(0, 5) == 0)
        tick = ($urandom_range(0, 1) == 1) ? 4'b0000 : (ph | 4'b1001);
      else begin
        ph = {ph[2:0], ph[3]};
        tick = ph;
      end
    end
  end

  // Monitor: every fetch the DUT presents is compared with the scoreboard.
  initial begin
    fetch_t e;
    forever begin
      @(negedge clk);
      if (!rst && running && tick == TICK_FETCH) begin
        if (exp_q.size() == 0) begin
          if (mon_strict) begin
            n_checks++;
            $display("FAIL unexpected_fetch: got din %0h pc %0h expected no fetch", din, pc);
          end
        end else begin
          e = exp_q.pop_front();
          check("fetch_din", din, e.word);
          check("fetch_pc", pc, e.addr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [8:0] rand_word();
    return {ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
  endfunction

  task automatic write_word(input logic [8:0] w);
    wr_en = 1'b1; wr_data = w;
    cyc();
    wr_en = 1'b0;
    if (prog_q.size() < DEPTH) prog_q.push_back(w);
  endtask

  task automatic push_run(input int nfetch);
    fetch_t e;
    for (int i = 0; i < nfetch; i++) begin
      e.word = prog_q[i % prog_q.size()];
      e.addr = AW'(i % prog_q.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin cyc(); k++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_halt();
    logic [3:0] prev;
    int k = 0;
    prev = tick;
    while (!halted && k < 40) begin prev = tick; cyc(); k++; end
    check("halted", halted, 1'b1);
    check("halt_on_wb", prev, TICK_WB);
    check("halt_pc", pc, prog_q.size() - 1);
    check("halt_din", din, prog_q[prog_q.size() - 1]);
    check("halt_count", count, prog_q.size());
    check("halt_running", running, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    exp_q.delete(); prog_q.delete();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1; wr_en = 1'b0; wr_data = 9'h000; start = 1'b0;
    cyc(); cyc();
    check("rst_count", count, 0);
    check("rst_pc", pc, 0);
    check("rst_din", din, 9'h000);
    check("rst_running", running, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_full", full, 1'b0);
    rst = 1'b0;
    cyc();

`ifdef INSTR_SEQ_LOOP_EN
    // Looping build: 3 words repeat 0,1,2,0,1 and never halt.
    write_word(9'h00D); write_word(9'h04A); write_word(9'h091);
    check("loop_count", count, 3);
    push_run(5);
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      cyc();
      check("loop_no_halt", halted, 1'b0);
      if (exp_q.size() == 0) mon_strict = 1'b0;
    end
    check("loop_drain", exp_q.size(), 0);
    check("loop_running", running, 1'b1);
    do_reset();
`else
    // start with an empty buffer is ignored.
    pulse_start(); cyc();
    check("empty_running", running, 1'b0);
    check("empty_din", din, 9'h000);
    check("empty_count", count, 0);

    // Two-word program: movi R1,5 ; add R1,R2.
    write_word(9'h00D); write_word(9'h04A);
    check("load2_count", count, 2);
    push_run(2);
    pulse_start();
    wait_drain(40);
    wait_halt();

    // Restart from HALT with start during tick 0100.
    k = 0;
    while (tick != 4'b0100 && k < 16) begin cyc(); k++; end
    push_run(2);
    pulse_start();
    check("midstart_pc_a", pc, 0);
    cyc();
    check("midstart_pc_b", pc, 0);
    wait_drain(40);
    wait_halt();

    // Write in HALT restarts the buffer, then 16 more writes overflow it.
    illegal_en = 1'b1;
    prog_q.delete();
    write_word(rand_word());
    check("haltwr_count", count, 1);
    check("haltwr_running", running, 1'b0);
    for (int i = 0; i < 16; i++) write_word(rand_word());
    check("full_count", count, DEPTH);
    check("full_flag", full, 1'b1);
    push_run(DEPTH);
    pulse_start();
    wait_drain(160);
    wait_halt();

    // Random runs, each reloaded from HALT; a stray write in RUN is ignored.
    for (int r = 0; r < 3; r++) begin
      prog_q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) write_word(rand_word());
      check("rand_count", count, n);
      for (int i = 0; i < $urandom_range(0, 3); i++) cyc();
      push_run(n);
      pulse_start();
      wr_en = 1'b1; wr_data = rand_word();
      cyc();
      wr_en = 1'b0;
      wait_drain(80);
      wait_halt();
    end

    // Reset while pc=3 aborts to LOAD immediately.
    do_reset();
    n = $urandom_range(5, 10);
    for (int i = 0; i < n; i++) write_word(rand_word());
    push_run(n);
    pulse_start();
    k = 0;
    while (exp_q.size() > n - 4 && k < 60) begin cyc(); k++; end
    check("abort_pc", pc, 3);
    rst = 1'b1;
    #1;
    check("abort_running", running, 1'b0);
    check("abort_count", count, 0);
    check("abort_pc0", pc, 0);
    check("abort_din", din, 9'h000);
    exp_q.delete(); prog_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream stage of the simple processor.
- Buffers a short program of 9-bit instructions entered from board switches, then plays them back on the processor's `din` input, one word per instruction cycle.
- Sequencing follows the processor's one-hot tick output: it fetches on tick 4'b0001 and writes back on tick 4'b1000.
- Flags the top level when the program has been fully issued.

Parameters:
- DEPTH, 16: number of instruction words the buffer holds (power of two, ≥2).
- AW, 4: address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe for wr_data (single-cycle pulse, already debounced).
- wr_data  input  9  instruction word to append to the buffer.
- start  input  1  pulse; begins playback from address 0.
- tick  input  4  one-hot tick from the processor's tick FSM.
- din  output  9  instruction presented to the processor.
- pc  output  AW  address of the word currently on din.
- count  output  AW+1  number of words loaded.
- full  output  1  count == DEPTH.
- running  output  1  state == RUN.
- halted  output  1  state == HALT.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- On reset:
  - state=LOAD, count=0, pc=0, fetched=0.
  - din=9'b0, running=0, halted=0, full=0.
  - Buffer contents are not reset.
- States are LOAD, RUN and HALT.
- LOAD:
  - wr_en && !full: mem[count[AW-1:0]] <= wr_data, count++.
  - wr_en && full: write ignored, count unchanged.
  - start && count!=0: go to RUN; pc=0, fetched=0.
  - start && count==0: ignored, stay in LOAD.
  - If wr_en and start occur in the same cycle, the write completes and RUN starts next cycle with the new count.
- RUN:
  - din = mem[pc], combinational read.
  - wr_en is ignored.
  - tick==4'b0001: fetched <= 1. The processor latches IR at the end of this tick.
  - tick==4'b1000 && fetched: the instruction is complete; fetched <= 0.
    - If pc == count-1: go to HALT.
    - Otherwise pc++.
  - tick==4'b1000 && !fetched (start arrived mid-instruction): no action. This guarantees word 0 is issued in full at the next fetch.
  - start is ignored while in RUN.
- HALT:
  - din holds the last word; pc holds count-1; halted=1.
  - The top level uses halted to freeze or ignore the processor.
  - start: return to RUN from pc=0, fetched=0, with the buffer and count kept.
  - wr_en in HALT clears count to 0, returns to LOAD, and writes the word at address 0 (count=1).
- Latency: one instruction per 4 ticks. `start` to first fetch is at most 4 clocks.
- Reset mid-RUN aborts immediately to LOAD with count=0.
- Illegal `tick` values (not one-hot) are treated as no-ops.

Optional Feature:
- Macro: INSTR_SEQ_LOOP_EN.
- Defined: at tick 4'b1000 with pc==count-1, pc wraps to 0 and the block stays in RUN. halted never asserts; start in RUN restarts at pc=0.
- Undefined: behaviour exactly as above (HALT at end of program).

Decomposition:
- Shared package holds:
  - state encoding (LOAD=2'd0, RUN=2'd1, HALT=2'd2);
  - tick constants TICK_FETCH=4'b0001, TICK_WB=4'b1000;
  - opcode constants (MOVI=3'b000, ADD=3'b001, ADDI=3'b010, SUB=3'b011), used by the bench.
- One sub-module: instr_buffer — DEPTH x 9 register array, synchronous write, combinational read, no reset.

Test Plan:
- Reset, load 9'h00D (movi R1,5) and 9'h04A (add R1,R2) then start → count=2. din=9'h00D during the first tick 0001 and 9'h04A during the second; halted rises at the end of the second tick 1000; pc=1.
- Assert start during tick 0100 → pc stays 0 through the first tick 1000; the first fetch sees 9'h00D.
- Write 17 words with DEPTH=16 → count=16, full=1; the 17th write is ignored and mem[0] is unchanged.
- start with count=0 → state remains LOAD, running=0, din=9'b0.
- Assert rst while pc=3 in RUN → next cycle: state LOAD, count=0, pc=0, din=0.
- INSTR_SEQ_LOOP_EN defined, 3 words loaded → pc sequence 0,1,2,0,1; halted never asserts over 24 clocks.
